// File: rtl/instr_loader.sv
// Byte-stream program loader: reads a 16-bit word count and N big-endian words into instruction memory, then releases the core.
// Optional trailer checksum (XOR of all data bytes) is enabled by defining LOADER_CKSUM_EN.
module instr_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] Instr_IN,
    output logic        Instr_W_en,
    output logic [8:0]  I_W_Addr,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        FLUSH,
`ifdef LOADER_CKSUM_EN
        CKSUM,
`endif
        RUN,
        ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  hdr_hi;
    logic [15:0] hdr_word;
    logic [23:0] partial;
    logic [1:0]  byte_cnt;
    logic [8:0]  word_addr;
    logic [8:0]  last_idx;
    logic        xfer;
    logic        word_done;
`ifdef LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    assign xfer      = in_valid && in_ready;
    assign hdr_word  = {hdr_hi, in_data};
    assign word_done = (state == DATA) && xfer && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) next_state = HDR_HI;
            end
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) next_state = HDR_LO;
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (hdr_word == 16'd0 || hdr_word > 16'd512) next_state = ERR;
                    else                                         next_state = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (word_done && word_addr == last_idx) next_state = FLUSH;
            end
            FLUSH: begin
`ifdef LOADER_CKSUM_EN
                next_state = CKSUM;
`else
                next_state = RUN;
`endif
            end
`ifdef LOADER_CKSUM_EN
            CKSUM: begin
                in_ready = 1'b1;
                if (in_valid) next_state = (in_data == cksum) ? RUN : ERR;
            end
`endif
            RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (load_start) next_state = HDR_HI;
            end
            ERR: begin
                err = 1'b1;
                if (load_start) next_state = HDR_HI;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word assembly: three bytes are buffered, the fourth completes the word and fires a one-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_hi     <= 8'd0;
            partial    <= 24'd0;
            byte_cnt   <= 2'd0;
            word_addr  <= 9'd0;
            last_idx   <= 9'd0;
            Instr_IN   <= 32'd0;
            I_W_Addr   <= 9'd0;
            Instr_W_en <= 1'b0;
`ifdef LOADER_CKSUM_EN
            cksum      <= 8'd0;
`endif
        end else begin
            Instr_W_en <= 1'b0;
            if (state == HDR_HI && xfer) begin
                hdr_hi <= in_data;
            end
            if (state == HDR_LO && xfer) begin
                byte_cnt  <= 2'd0;
                word_addr <= 9'd0;
                last_idx  <= hdr_word[8:0] - 9'd1;
`ifdef LOADER_CKSUM_EN
                cksum     <= 8'd0;
`endif
            end
            if (state == DATA && xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CKSUM_EN
                cksum    <= cksum ^ in_data;
`endif
                if (byte_cnt == 2'd3) begin
                    Instr_W_en <= 1'b1;
                    Instr_IN   <= {partial, in_data};
                    I_W_Addr   <= word_addr;
                    word_addr  <= word_addr + 9'd1;
                end else begin
                    partial <= {partial[15:0], in_data};
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader: expected writes are queued as bytes are issued and popped by a monitor.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr_IN;
    logic        Instr_W_en;
    logic [8:0]  I_W_Addr;
    logic        cpu_rst;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    logic [8:0]  last_addr_seen = 9'd0;
    logic [31:0] hold_data = 32'd0;
    logic [8:0]  hold_addr = 9'd0;
    wr_t         exp_q[$];
    wr_t         mon_w;
    logic [7:0]  byte_q[$];

    instr_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Instr_IN   (Instr_IN),
        .Instr_W_en (Instr_W_en),
        .I_W_Addr   (I_W_Addr),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write pulse must match the head of the scoreboard; between pulses the outputs must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_data = 32'd0;
            hold_addr = 9'd0;
        end else if (Instr_W_en) begin
            writes_seen++;
            last_addr_seen = I_W_Addr;
            checkOutput("cpu_rst_during_write", {31'd0, cpu_rst}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got 0x%0h@0x%0h, expected no write", Instr_IN, I_W_Addr);
                hold_data = Instr_IN;
                hold_addr = I_W_Addr;
            end else begin
                mon_w = exp_q.pop_front();
                checkOutput("write_data", Instr_IN, mon_w.data);
                checkOutput("write_addr", {23'd0, I_W_Addr}, {23'd0, mon_w.addr});
                hold_data = mon_w.data;
                hold_addr = mon_w.addr;
            end
        end else begin
            checkOutput("hold_data", Instr_IN, hold_data);
            checkOutput("hold_addr", {23'd0, I_W_Addr}, {23'd0, hold_addr});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseStart();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    // Present one byte until it is accepted (bounded), optionally with a stray load_start alongside.
    task automatic applyStimulus(input logic [7:0] b, input bit with_start);
        int budget = 0;
        bit ok = 1'b0;
        in_data    = b;
        in_valid   = 1'b1;
        load_start = with_start;
        while (!ok && budget < 16) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=0 for 16 cycles, expected 1");
        end
    endtask

    task automatic fillRandom(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word i is bytes 4i..4i+3 big-endian at address i; a bad header loads nothing.
    task automatic doLoad(input int n, input int gap_mode, input bit bad_trailer, input bit stray_start);
        int         w0 = writes_seen;
        bit         hdr_ok = (n >= 1 && n <= 512);
        logic [15:0] h = 16'(n);
        logic [7:0] ck = 8'd0;
        bit         exp_done;
        wr_t        w;
        pulseStart();
        applyStimulus(h[15:8], 1'b0);
        applyStimulus(h[7:0], 1'b0);
        if (!hdr_ok) begin
            idle(1);
            checkOutput("hdr_err", {31'd0, err}, 32'd1);
            checkOutput("hdr_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            checkOutput("hdr_err_done", {31'd0, done}, 32'd0);
            checkOutput("hdr_err_writes", 32'(writes_seen - w0), 32'd0);
            return;
        end
        for (int i = 0; i < 4 * n; i++) begin
            if (gap_mode == 1 && i > 0) idle(1);
            if (gap_mode == 2) idle($urandom_range(0, 2));
            if (i % 4 == 3) begin
                w.addr = 9'(i / 4);
                w.data = {byte_q[i-3], byte_q[i-2], byte_q[i-1], byte_q[i]};
                exp_q.push_back(w);
            end
            ck ^= byte_q[i];
            applyStimulus(byte_q[i], stray_start && ($urandom_range(0, 5) == 0));
        end
        checkOutput("flush_we", {31'd0, Instr_W_en}, 32'd1);
        checkOutput("flush_cpu_rst", {31'd0, cpu_rst}, 32'd1);
`ifdef LOADER_CKSUM_EN
        applyStimulus(bad_trailer ? (ck ^ 8'h01) : ck, 1'b0);
        exp_done = !bad_trailer;
`else
        idle(1);
        exp_done = 1'b1;
`endif
        checkOutput("end_done", {31'd0, done}, {31'd0, exp_done});
        checkOutput("end_err", {31'd0, err}, {31'd0, !exp_done});
        checkOutput("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, !exp_done});
        checkOutput("end_writes", 32'(writes_seen - w0), 32'(n));
        checkOutput("end_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wr_t w;
        int  w0;
        rst        = 1'b1;
        load_start = 1'b0;
        in_data    = 8'd0;
        in_valid   = 1'b0;
        idle(3);
        rst = 1'b0;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("rst_we", {31'd0, Instr_W_en}, 32'd0);
        checkOutput("rst_instr", Instr_IN, 32'd0);
        checkOutput("rst_addr", {23'd0, I_W_Addr}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);

        // Directed two-word load, continuous valid.
        byte_q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h07};
        doLoad(2, 0, 1'b0, 1'b0);

        // Zero and oversized headers abort; a fresh load recovers.
        doLoad(0, 0, 1'b0, 1'b0);
        fillRandom(4);
        doLoad(1, 0, 1'b0, 1'b0);
        doLoad(513, 0, 1'b0, 1'b0);

        // Single word with in_valid low every other cycle.
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        doLoad(1, 1, 1'b0, 1'b0);

        // Random small loads with random gaps and stray load_start pulses.
        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 8);
            fillRandom(4 * n);
            doLoad(n, 2, 1'b0, 1'b1);
        end

        // Full-size program.
        fillRandom(2048);
        doLoad(512, 0, 1'b0, 1'b0);
        checkOutput("last_addr_512", {23'd0, last_addr_seen}, 32'h1FF);

        // Reset after 6 of 8 data bytes: only the first word is written.
        w0 = writes_seen;
        fillRandom(8);
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h02, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                w.addr = 9'd0;
                w.data = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
                exp_q.push_back(w);
            end
            applyStimulus(byte_q[i], 1'b0);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("midrst_we", {31'd0, Instr_W_en}, 32'd0);
        checkOutput("midrst_instr", Instr_IN, 32'd0);
        checkOutput("midrst_addr", {23'd0, I_W_Addr}, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        checkOutput("midrst_err", {31'd0, err}, 32'd0);
        idle(4);
        checkOutput("midrst_writes", 32'(writes_seen - w0), 32'd1);
        checkOutput("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Load after reset starts cleanly from word 0.
        fillRandom(12);
        doLoad(3, 2, 1'b0, 1'b0);

`ifdef LOADER_CKSUM_EN
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        doLoad(1, 0, 1'b0, 1'b0);
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        doLoad(1, 0, 1'b1, 1'b0);
`endif

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
